// File: rtl/fp_wb_pkg.sv
// Shared types and defaults for the FP writeback arbiter slice.
package fp_wb_pkg;

    localparam int DEF_REG_NUM       = 32;
    localparam int DEF_FIFO_DEPTH    = 2;
    localparam int DEF_LSU_BURST_MAX = 4;
    localparam int WB_AW             = $clog2(DEF_REG_NUM);
    localparam int WB_DW             = 32;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_SRC_LSU  = 2'd0,
        WB_SRC_PIPE = 2'd1,
        WB_SRC_ITER = 2'd2
    } wb_src_e;

endpackage

// File: rtl/fp_wb_fifo.sv
// Per-source writeback queue: circular buffer with occupancy counter and
// registered not-full (ready) / empty flags.
module fp_wb_fifo
    import fp_wb_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      push_valid,
    output logic      push_ready,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t      mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_nxt;
    logic           not_full_q, empty_q;
    logic           push_fire, pop_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready is the registered not-full, so a full queue refuses even while popping.
    assign push_fire  = push_valid && not_full_q;
    assign pop_fire   = pop && !empty_q;
    assign push_ready = not_full_q;
    assign empty      = empty_q;
    assign head       = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push_fire, pop_fire})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            not_full_q <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            if (push_fire) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_fire)  rd_ptr <= ptr_inc(rd_ptr);
            count      <= count_nxt;
            not_full_q <= (count_nxt != CW'(DEPTH));
            empty_q    <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fp_writeback_arbiter.sv
// Merges LSU, pipelined-FPU and iterative-FPU results onto register-file and
// scoreboard write port 1: LSU priority, pipe/iter round-robin, LSU burst cap.
module fp_writeback_arbiter
    import fp_wb_pkg::*;
#(
    parameter int REG_NUM       = DEF_REG_NUM,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int LSU_BURST_MAX = DEF_LSU_BURST_MAX,
    localparam int AW           = $clog2(REG_NUM)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic [31:0]   lsu_data,
    input  logic          pipe_valid,
    output logic          pipe_ready,
    input  logic [AW-1:0] pipe_addr,
    input  logic [31:0]   pipe_data,
    input  logic          iter_valid,
    output logic          iter_ready,
    input  logic [AW-1:0] iter_addr,
    input  logic [31:0]   iter_data,
    output logic          wb_write_enable,
    output logic [AW-1:0] wb_write_addr,
    output logic [31:0]   wb_write_data,
    output logic          sb_clear_enable,
    output logic [AW-1:0] sb_clear_addr,
    output logic          sb_clear_data,
    output logic          prio_reg,
    output logic          prio_scoreboard
);

    localparam int BW = $clog2(LSU_BURST_MAX + 1);

    wb_entry_t lsu_in, pipe_in, iter_in;
    wb_entry_t lsu_head, pipe_head, iter_head;
    logic      lsu_empty, pipe_empty, iter_empty;
    logic      lsu_pop, pipe_pop, iter_pop;

    logic      fpu_ne, starve;
    wb_src_e   fpu_src;
    logic      vld_p0;
    wb_src_e   src_p0;
    wb_entry_t entry_p0;

    logic [BW-1:0] burst_q;
    logic          rr_iter_q;
    logic          vld_p1;
    wb_entry_t     entry_p1;

    assign lsu_in  = '{addr: WB_AW'(lsu_addr),  data: lsu_data};
    assign pipe_in = '{addr: WB_AW'(pipe_addr), data: pipe_data};
    assign iter_in = '{addr: WB_AW'(iter_addr), data: iter_data};

    fp_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk(clk), .rstn(rstn),
        .push_valid(lsu_valid), .push_ready(lsu_ready), .push_entry(lsu_in),
        .pop(lsu_pop), .head(lsu_head), .empty(lsu_empty)
    );

    fp_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_pipe_fifo (
        .clk(clk), .rstn(rstn),
        .push_valid(pipe_valid), .push_ready(pipe_ready), .push_entry(pipe_in),
        .pop(pipe_pop), .head(pipe_head), .empty(pipe_empty)
    );

    fp_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_iter_fifo (
        .clk(clk), .rstn(rstn),
        .push_valid(iter_valid), .push_ready(iter_ready), .push_entry(iter_in),
        .pop(iter_pop), .head(iter_head), .empty(iter_empty)
    );

    // Stage p0: pick one queue head and pop it in the same cycle.
    assign fpu_ne = !pipe_empty || !iter_empty;
    assign starve = fpu_ne && (burst_q >= BW'(LSU_BURST_MAX));

    always_comb begin
        fpu_src  = WB_SRC_PIPE;
        vld_p0   = 1'b0;
        src_p0   = WB_SRC_LSU;
        entry_p0 = '0;
        if (!pipe_empty && !iter_empty)
            fpu_src = rr_iter_q ? WB_SRC_ITER : WB_SRC_PIPE;
        else if (!iter_empty)
            fpu_src = WB_SRC_ITER;
        if (!lsu_empty && !starve) begin
            vld_p0 = 1'b1;
            src_p0 = WB_SRC_LSU;
        end else if (fpu_ne) begin
            vld_p0 = 1'b1;
            src_p0 = fpu_src;
        end
        if (vld_p0) begin
            case (src_p0)
                WB_SRC_PIPE: entry_p0 = pipe_head;
                WB_SRC_ITER: entry_p0 = iter_head;
                default:     entry_p0 = lsu_head;
            endcase
        end
    end

    assign lsu_pop  = vld_p0 && (src_p0 == WB_SRC_LSU);
    assign pipe_pop = vld_p0 && (src_p0 == WB_SRC_PIPE);
    assign iter_pop = vld_p0 && (src_p0 == WB_SRC_ITER);

    // Stage p1: registered write to both register file and scoreboard.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            burst_q   <= '0;
            rr_iter_q <= 1'b0;
            vld_p1    <= 1'b0;
            entry_p1  <= '0;
        end else begin
            vld_p1   <= vld_p0;
            entry_p1 <= entry_p0;
            if (pipe_pop || iter_pop) begin
                rr_iter_q <= ~rr_iter_q;
                burst_q   <= '0;
            end else if (!fpu_ne) begin
                burst_q <= '0;
            end else if (lsu_pop) begin
                burst_q <= burst_q + 1'b1;
            end
        end
    end

    assign wb_write_enable = vld_p1;
    assign wb_write_addr   = entry_p1.addr[AW-1:0];
    assign wb_write_data   = entry_p1.data;
    assign sb_clear_enable = vld_p1;
    assign sb_clear_addr   = entry_p1.addr[AW-1:0];
    // Busy-clear loses to the ID-stage busy-set on port 2 at the same address.
    assign sb_clear_data   = 1'b0;
    assign prio_reg        = 1'b1;
    assign prio_scoreboard = 1'b1;

endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Self-checking bench for fp_writeback_arbiter: vector table plus hand-written
// multi-cycle sequences, with an expected-write scoreboard queue.
module tb_fp_writeback_arbiter;

    logic        clk;
    logic        rstn;
    logic        lsu_valid, lsu_ready, pipe_valid, pipe_ready, iter_valid, iter_ready;
    logic [4:0]  lsu_addr, pipe_addr, iter_addr;
    logic [31:0] lsu_data, pipe_data, iter_data;
    logic        wb_write_enable, sb_clear_enable, sb_clear_data, prio_reg, prio_scoreboard;
    logic [4:0]  wb_write_addr, sb_clear_addr;
    logic [31:0] wb_write_data;

    fp_writeback_arbiter dut (
        .clk(clk), .rstn(rstn),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .iter_valid(iter_valid), .iter_ready(iter_ready), .iter_addr(iter_addr), .iter_data(iter_data),
        .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
        .sb_clear_enable(sb_clear_enable), .sb_clear_addr(sb_clear_addr), .sb_clear_data(sb_clear_data),
        .prio_reg(prio_reg), .prio_scoreboard(prio_scoreboard)
    );

    localparam int SRC_LSU = 0, SRC_PIPE = 1, SRC_ITER = 2;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          exp_cyc;
    } exp_t;

    typedef struct {
        int          src;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_wr(input logic [4:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.addr = a; e.data = d; e.exp_cyc = c;
        sbq.push_back(e);
    endfunction

    // Write-port monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (wb_write_enable || sb_clear_enable) begin
            check("sb_clear_enable", 32'(sb_clear_enable), 32'(wb_write_enable));
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected no write (cycle %0d)",
                         wb_write_addr, wb_write_data, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("wb_write_addr", 32'(wb_write_addr), 32'(e.addr));
                check("wb_write_data", wb_write_data, e.data);
                check("sb_clear_addr", 32'(sb_clear_addr), 32'(e.addr));
                if (e.exp_cyc >= 0) check("write_latency_cycle", 32'(cyc), 32'(e.exp_cyc));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive_src(input int s, input logic v, input logic [4:0] a, input logic [31:0] d);
        case (s)
            SRC_LSU:  begin lsu_valid  = v; lsu_addr  = a; lsu_data  = d; end
            SRC_PIPE: begin pipe_valid = v; pipe_addr = a; pipe_data = d; end
            default:  begin iter_valid = v; iter_addr = a; iter_data = d; end
        endcase
    endtask

    function automatic logic rdy(input int s);
        return (s == SRC_LSU) ? lsu_ready : (s == SRC_PIPE) ? pipe_ready : iter_ready;
    endfunction

    // Called at posedge+#1; returns at posedge+#1 just after the handshake edge.
    task automatic send(input int s, input logic [4:0] a, input logic [31:0] d);
        int t;
        t = 0;
        drive_src(s, 1'b1, a, d);
        while (!rdy(s) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check("send_ready_timeout", 32'(rdy(s)), 32'd1);
        @(posedge clk); #1;
        drive_src(s, 1'b0, a, d);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (t >= 300) check("drain_timeout", 32'(sbq.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        drive_src(SRC_LSU, 1'b0, 5'd0, 32'd0);
        drive_src(SRC_PIPE, 1'b0, 5'd0, 32'd0);
        drive_src(SRC_ITER, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{SRC_PIPE, 5'd5,  32'h3F80_0000, 5'd5,  32'h3F80_0000, 2};
        vecs[1] = '{SRC_LSU,  5'd0,  32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 2};
        vecs[2] = '{SRC_ITER, 5'd31, 32'h4049_0FDB, 5'd31, 32'h4049_0FDB, 2};
        vecs[3] = '{SRC_PIPE, 5'd0,  32'h0000_0000, 5'd0,  32'h0000_0000, 2};
        vecs[4] = '{SRC_LSU,  5'd31, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 2};
        vecs[5] = '{SRC_ITER, 5'd12, 32'h8000_0001, 5'd12, 32'h8000_0001, 2};

        rstn = 1'b0;
        drive_src(SRC_LSU, 1'b0, 5'd0, 32'd0);
        drive_src(SRC_PIPE, 1'b0, 5'd0, 32'd0);
        drive_src(SRC_ITER, 1'b0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_wb_enable", 32'(wb_write_enable), 32'd0);
        check("reset_sb_enable", 32'(sb_clear_enable), 32'd0);
        check("reset_wb_addr", 32'(wb_write_addr), 32'd0);
        check("reset_wb_data", wb_write_data, 32'd0);
        check("reset_sb_addr", 32'(sb_clear_addr), 32'd0);
        check("reset_readies", {29'd0, lsu_ready, pipe_ready, iter_ready}, 32'd0);
        check("sb_clear_data", 32'(sb_clear_data), 32'd0);
        check("prio_selects", {30'd0, prio_reg, prio_scoreboard}, 32'd3);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", {29'd0, lsu_ready, pipe_ready, iter_ready}, 32'd7);
        @(posedge clk); #1;

        // Single transfers from an idle arbiter: 2-cycle latency, address passthrough.
        for (int i = 0; i < 6; i++) begin
            expect_wr(vecs[i].exp_addr, vecs[i].exp_data, cyc + vecs[i].exp_lat);
            send(vecs[i].src, vecs[i].addr, vecs[i].data);
            drain();
        end

        // All three at once after reset: LSU, then pipe, then iter.
        reset_dut();
        expect_wr(5'd1, 32'h1111_0001, -1);
        expect_wr(5'd2, 32'h2222_0002, -1);
        expect_wr(5'd3, 32'h3333_0003, -1);
        fork
            send(SRC_LSU,  5'd1, 32'h1111_0001);
            send(SRC_PIPE, 5'd2, 32'h2222_0002);
            send(SRC_ITER, 5'd3, 32'h3333_0003);
        join
        drain();

        // Pipe and iter contending, LSU idle: strict alternation starting with pipe.
        for (int k = 0; k < 3; k++) begin
            expect_wr(5'(10 + k), 32'hA000_0000 + 32'(k), -1);
            expect_wr(5'(20 + k), 32'hB000_0000 + 32'(k), -1);
        end
        fork
            for (int k = 0; k < 3; k++) send(SRC_PIPE, 5'(10 + k), 32'hA000_0000 + 32'(k));
            for (int k = 0; k < 3; k++) send(SRC_ITER, 5'(20 + k), 32'hB000_0000 + 32'(k));
        join
        drain();

        // Continuous LSU with one pipe entry: four LSU writes, then the pipe write.
        for (int k = 0; k < 4; k++) expect_wr(5'(16 + k), 32'hC000_0000 + 32'(k), -1);
        expect_wr(5'd7, 32'h7777_7777, -1);
        for (int k = 4; k < 8; k++) expect_wr(5'(16 + k), 32'hC000_0000 + 32'(k), -1);
        fork
            for (int k = 0; k < 8; k++) send(SRC_LSU, 5'(16 + k), 32'hC000_0000 + 32'(k));
            send(SRC_PIPE, 5'd7, 32'h7777_7777);
        join
        drain();

        // Pipe back-pressure while LSU holds the port: ready drops after two accepts.
        for (int k = 0; k < 4; k++) expect_wr(5'(8 + k), 32'hD000_0000 + 32'(k), -1);
        expect_wr(5'd24, 32'hE000_0000, -1);
        expect_wr(5'd12, 32'hD000_0004, -1);
        expect_wr(5'd13, 32'hD000_0005, -1);
        expect_wr(5'd25, 32'hE000_0001, -1);
        expect_wr(5'd26, 32'hE000_0002, -1);
        fork
            for (int k = 0; k < 6; k++) send(SRC_LSU, 5'(8 + k), 32'hD000_0000 + 32'(k));
            begin
                send(SRC_PIPE, 5'd24, 32'hE000_0000);
                send(SRC_PIPE, 5'd25, 32'hE000_0001);
                check("pipe_ready_full", 32'(pipe_ready), 32'd0);
                send(SRC_PIPE, 5'd26, 32'hE000_0002);
            end
        join
        drain();

        // Reset with entries queued in every source: only the pre-reset write appears.
        drive_src(SRC_LSU,  1'b1, 5'd1, 32'hF000_0001);
        drive_src(SRC_PIPE, 1'b1, 5'd2, 32'hF000_0002);
        drive_src(SRC_ITER, 1'b1, 5'd3, 32'hF000_0003);
        expect_wr(5'd1, 32'hF000_0001, cyc + 2);
        @(posedge clk); #1;
        drive_src(SRC_LSU,  1'b1, 5'd4, 32'hF000_0004);
        drive_src(SRC_PIPE, 1'b1, 5'd5, 32'hF000_0005);
        drive_src(SRC_ITER, 1'b1, 5'd6, 32'hF000_0006);
        @(posedge clk); #1;
        drive_src(SRC_LSU,  1'b0, 5'd0, 32'd0);
        drive_src(SRC_PIPE, 1'b0, 5'd0, 32'd0);
        drive_src(SRC_ITER, 1'b0, 5'd0, 32'd0);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_wb_enable", 32'(wb_write_enable), 32'd0);
        check("midreset_wb_data", wb_write_data, 32'd0);
        check("midreset_readies", {29'd0, lsu_ready, pipe_ready, iter_ready}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("postreset_wb_enable_1", 32'(wb_write_enable), 32'd0);
        check("postreset_readies", {29'd0, lsu_ready, pipe_ready, iter_ready}, 32'd7);
        @(negedge clk);
        check("postreset_wb_enable_2", 32'(wb_write_enable), 32'd0);
        repeat (6) @(negedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
